// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package rv_fetch_pkg;

    // Opcode value that halts fetch once its word is delivered.
    localparam logic [6:0] HALT_OPCODE = 7'h7F;

    // PC control codes: RUN advances the PC, HOLD freezes it.
    localparam logic [6:0] PC_SCR_RUN  = 7'h00;
    localparam logic [6:0] PC_SCR_HOLD = 7'h7F;

    // Opcode field position within an instruction word.
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
module fetch_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic                  pop,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_instr,
    output logic [CW-1:0]         count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][ADDR_WIDTH+DATA_WIDTH-1:0] mem;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Pop on empty is ignored; push on full is only allowed alongside a pop.
    always_comb begin
        pop_ok  = pop & (count != '0);
        push_ok = push & ((count != FULL) | pop_ok);
    end

    // Storage, wrap-around pointers and occupancy; flush empties without clearing data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {push_pc, push_instr};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Head of queue is presented directly from storage.
    always_comb begin
        valid      = (count != '0);
        head_pc    = mem[rd_ptr][ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        head_instr = mem[rd_ptr][DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: issues PC to imem, captures responses into a FIFO for decode,
// back-pressures the PC via pc_scr and freezes after a halt opcode.
module instr_fetch_stage #(
    parameter int         ADDR_WIDTH  = 32,
    parameter int         DATA_WIDTH  = 32,
    parameter int         FIFO_DEPTH  = 2,
    parameter logic [6:0] HALT_OPCODE = rv_fetch_pkg::HALT_OPCODE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [6:0]            pc_scr_out,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  flush,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic                  halted
);

    import rv_fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_e          state_q, state_d;
    logic [CW-1:0]         count;
    logic [OW-1:0]         occupancy;
    logic                  pop;
    logic                  issue;
    // vld_pipe[0]: request issued this cycle, vld_pipe[1]: response due this cycle.
    logic [1:0]            vld_pipe;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  flush_q;
    logic                  accept;
    logic                  halt_hit;

    // Issue only while running and while every outstanding word is guaranteed a FIFO slot.
    always_comb begin
        pop         = id_valid & id_ready;
        occupancy   = OW'(count) + OW'(vld_pipe[1]) - OW'(pop);
        issue       = (state_q == ST_RUN) & ~flush & (occupancy < OW'(FIFO_DEPTH));
        vld_pipe[0] = issue;
        imem_en     = issue;
        imem_addr   = pc_in;
        pc_scr_out  = issue ? PC_SCR_RUN : PC_SCR_HOLD;
    end

    // Track the in-flight request, its address, and a one-cycle flush shadow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe[1] <= 1'b0;
            req_pc      <= '0;
            flush_q     <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (issue)
                req_pc <= pc_in;
            flush_q <= flush;
        end
    end

    // A response is kept unless flushed (now or last cycle) or fetch has already halted.
    always_comb begin
        accept   = vld_pipe[1] & ~flush & ~flush_q & (state_q == ST_RUN);
        halt_hit = accept & (imem_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Next state: a delivered halt word freezes fetch until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt_hit) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    assign halted = (state_q == ST_HALTED);

    fetch_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (accept),
        .push_pc    (req_pc),
        .push_instr (imem_rdata),
        .pop        (pop),
        .valid      (id_valid),
        .head_pc    (id_pc),
        .head_instr (id_instr),
        .count      (count)
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench: behavioural PC and 1-cycle imem around the fetch stage.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [6:0]  pc_scr_out;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;

    logic [31:0] imem [64];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    instr_fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_scr_out (pc_scr_out),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // PC advances only on pc_scr == 0; cleared together with the DUT.
    always @(posedge clk) begin
        if (!rst)
            pc_in <= '0;
        else if (pc_scr_out == 7'h00)
            pc_in <= pc_in + 1;
    end

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) begin
        if (imem_en)
            imem_rdata <= imem[imem_addr[5:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    function automatic logic [31:0] word(input int i);
        return (32'(i) << 7) | 32'h13;
    endfunction

    // Two reset edges, optional reset-state checks, release at cycle 0.
    task automatic do_reset(input bit check);
        rst = 1'b0;
        flush = 1'b0;
        id_ready = 1'b0;
        tick();
        tick();
        if (check) begin
            chk("rst_valid", id_valid, 0);
            chk("rst_instr", id_instr, 0);
            chk("rst_pc", id_pc, 0);
            chk("rst_halted", halted, 0);
        end
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        id_ready = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = word(i);

        // Streaming at full rate
        do_reset(1);
        id_ready = 1'b1;
        wait_to(1);
        chk("stream_v1", id_valid, 0);
        chk("stream_scr1", pc_scr_out, 7'h00);
        for (int k = 0; k <= 5; k++) begin
            wait_to(k + 2);
            chk("stream_valid", id_valid, 1);
            chk("stream_pc", id_pc, k);
            chk("stream_instr", id_instr, word(k));
            chk("stream_scr", pc_scr_out, 7'h00);
        end

        // Back-pressure: decode stalls with head pc 5
        id_ready = 1'b0;
        wait_to(10);
        chk("bp_valid", id_valid, 1);
        chk("bp_pc", id_pc, 5);
        chk("bp_scr", pc_scr_out, 7'h7F);
        chk("bp_pcin", pc_in, 7);
        chk("bp_en", imem_en, 0);
        id_ready = 1'b1;
        for (int k = 6; k <= 9; k++) begin
            wait_to(k + 5);
            chk("bp_resume_valid", id_valid, 1);
            chk("bp_resume_pc", id_pc, k);
        end

        // Flush with one buffered and one in flight
        do_reset(0);
        id_ready = 1'b1;
        wait_to(4);
        chk("fl_head", id_pc, 2);
        flush = 1'b1;
        #1;
        chk("fl_en", imem_en, 0);
        chk("fl_scr", pc_scr_out, 7'h7F);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_valid", id_valid, 0);
        chk("fl_pcin", pc_in, 4);
        chk("fl_en_after", imem_en, 1);
        wait_to(6);
        chk("fl_valid2", id_valid, 0);
        wait_to(7);
        chk("fl_resume_valid", id_valid, 1);
        chk("fl_resume_pc", id_pc, 4);
        wait_to(8);
        chk("fl_resume_pc2", id_pc, 5);

        // Halt on word 4
        imem[4] = 32'h0000_007F;
        do_reset(0);
        id_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            wait_to(k);
            chk("halt_pc", id_pc, k - 2);
            chk("halt_not_yet", halted, 0);
        end
        wait_to(6);
        chk("halt_set", halted, 1);
        chk("halt_word_pc", id_pc, 4);
        chk("halt_word", id_instr, 32'h7F);
        chk("halt_pcin", pc_in, 6);
        wait_to(7);
        chk("halt_drop", id_valid, 0);
        wait_to(9);
        chk("halt_frozen_pc", pc_in, 6);
        chk("halt_scr", pc_scr_out, 7'h7F);
        chk("halt_en", imem_en, 0);
        chk("halt_hold", halted, 1);
        chk("halt_empty", id_valid, 0);

        // Flush coincides with halt response: halt is not taken
        do_reset(0);
        id_ready = 1'b1;
        wait_to(5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fh_halted", halted, 0);
        chk("fh_valid", id_valid, 0);
        chk("fh_pcin", pc_in, 5);
        chk("fh_en", imem_en, 1);
        wait_to(8);
        chk("fh_resume_valid", id_valid, 1);
        chk("fh_resume_pc", id_pc, 5);
        chk("fh_halted2", halted, 0);
        imem[4] = word(4);

        // Reset while halted with a full FIFO
        imem[1] = 32'h0000_007F;
        do_reset(0);
        id_ready = 1'b0;
        wait_to(3);
        chk("rh_halted", halted, 1);
        chk("rh_valid", id_valid, 1);
        chk("rh_head", id_pc, 0);
        chk("rh_pcin", pc_in, 2);
        imem[1] = word(1);
        do_reset(1);
        id_ready = 1'b1;
        wait_to(2);
        chk("rh_restart_pc0", id_pc, 0);
        chk("rh_restart_v0", id_valid, 1);
        wait_to(3);
        chk("rh_restart_pc1", id_pc, 1);
        chk("rh_restart_i1", id_instr, word(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
